dual_digit_scan: RTL and testbench
==================================

Name: dual_digit_scan

Overview:
- Time-multiplexes two 4-bit hex values onto one shared active-low 7-segment bus with two active-low digit enables.
- Sits between the switch inputs (s1 → left digit, s2 → right digit) and the board's segment/enable pins, directly upstream of the display pins in the top level.
- Inserts a blanking interval between digits to prevent ghosting.
- Latches both inputs once per frame so a digit never changes mid-frame.

Parameters:
- DWELL_CYCLES, 24000, clk cycles each digit is lit (must be >= 1).
- BLANK_CYCLES, 240, clk cycles with both digits off after each dwell (0 allowed).
- CNT_W, $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1), dwell/blank counter width (derived, not overridden).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- s1  input  4  left-digit value
- s2  input  4  right-digit value
- seg  output  7  segments {g,f,e,d,c,b,a}; active-low
- hex1_num  output  1  left-digit enable; active-low
- hex2_num  output  1  right-digit enable; active-low
- frame_tick  output  1  one-cycle pulse on the cycle new s1/s2 are latched

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- FSM states: SHOW1, BLANK1, SHOW2, BLANK2. Cycle order is SHOW1 → BLANK1 → SHOW2 → BLANK2 → SHOW1.
- State duration:
  - SHOW states last exactly DWELL_CYCLES cycles.
  - BLANK states last exactly BLANK_CYCLES cycles.
  - Frame period = 2*(DWELL_CYCLES+BLANK_CYCLES).
- Counter: counts 0..N-1 within a state. On N-1 the state advances and the counter returns to 0.
- BLANK_CYCLES=0: blank states are skipped entirely (SHOW1 → SHOW2 → SHOW1). There are no dead cycles.
- Input latch:
  - d1_q <= s1 and d2_q <= s2 only on the edge entering SHOW1.
  - frame_tick=1 for the first cycle of SHOW1, and 0 otherwise.
  - Inputs are ignored at all other times.
- Reset:
  - On any edge with reset=1: state=BLANK2, counter=0, d1_q=d2_q=0.
  - Outputs during reset: seg=7'h7F, hex1_num=1, hex2_num=1, frame_tick=0.
  - First latch occurs after BLANK_CYCLES cycles following reset release, or on the first edge after release if BLANK_CYCLES=0.
- Outputs are registered, computed from next-state and next-latched values, so they change on the same edge as the state:
  - SHOW1: hex1_num=0, hex2_num=1, seg=decode(d1_q).
  - SHOW2: hex1_num=1, hex2_num=0, seg=decode(d2_q).
  - BLANK1/BLANK2: both enables=1, seg=7'h7F.
- Invariant: hex1_num and hex2_num are never both 0 in any cycle, including the reset edge and reset release.
- Reset mid-operation: takes effect on the next edge regardless of state or counter. There is no partial dwell afterwards.
- Decode: full hex 0-F (A,b,C,d,E,F). The 4-bit inputs cannot overflow; no arithmetic is performed in this block.

Optional Feature:
- Macro: DUAL_DIGIT_LZ_BLANK_EN (leading-zero suppression).
- Defined: when d1_q==0, SHOW1 drives hex1_num=1 and seg=7'h7F. Timing is unchanged; the slot is simply dark. The right digit always displays, including 0.
- Undefined: a left-digit 0 displays as 7'b1000000.

Decomposition:
- Package dual_digit_pkg:
  - scan_state_t enum {SHOW1,BLANK1,SHOW2,BLANK2}.
  - SEG_OFF = 7'h7F.
  - SEG_W = 7.
- Sub-module seven_seg_decoder: purely combinational, 4-bit in → 7-bit active-low out. It is instantiated once and fed by a mux of d1_q/d2_q selected from next-state.

Test Plan:
Bench uses DWELL_CYCLES=4, BLANK_CYCLES=2 unless noted.
1. Reset 3 cycles, s1=4, s2=5, release → 2 cycles all-off with seg=7'h7F. Then frame_tick=1 for 1 cycle. Then 4 cycles hex1_num=0, seg=7'b0011001. Then 2 cycles off. Then 4 cycles hex2_num=0, seg=7'b0010010. Pattern repeats every 12 cycles.
2. Change s1 from 4 to 8 in the 2nd cycle of SHOW2 → current frame is unchanged. Next SHOW1 shows seg=7'b0000000, and the change follows the frame_tick.
3. Random s1/s2 every cycle plus random reset for 10k cycles → hex1_num&hex2_num never both 0. frame_tick period is exactly 12 cycles between resets.
4. BLANK_CYCLES=0 instance, s1=C, s2=F → alternates 4 cycles seg=7'b1000110 / 4 cycles seg=7'b0001110. There is never a cycle with both enables high after reset release.
5. Assert reset in the 3rd cycle of SHOW1 → next edge gives both enables=1, seg=7'h7F, d1_q=0. Sequence restarts exactly as in test 1.
6. s1=0, s2=5:
   - With DUAL_DIGIT_LZ_BLANK_EN: SHOW1 gives hex1_num=1, seg=7'h7F. SHOW2 gives hex2_num=0, seg=7'b0010010.
   - Without the macro: SHOW1 gives hex1_num=0, seg=7'b1000000.

Source files
------------

// File: rtl/dual_digit_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment scanner.
package dual_digit_pkg;

   localparam int SEG_W = 7;
   localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

   typedef enum logic [1:0] {
      SHOW1  = 2'd0,
      BLANK1 = 2'd1,
      SHOW2  = 2'd2,
      BLANK2 = 2'd3
   } scan_state_t;

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex (0-F) to active-low 7-segment decode, segment order {g,f,e,d,c,b,a}.
module seven_seg_decoder
   import dual_digit_pkg::*;
(
   input  logic [3:0]       digit,
   output logic [SEG_W-1:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      case (digit)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/dual_digit_scan.sv
// Two-digit time-multiplexed 7-segment scanner with inter-digit blanking and per-frame input latch.
// Optional build macro: DUAL_DIGIT_LZ_BLANK_EN (leading-zero suppression on the left digit).
//
// state  | meaning
// SHOW1  | left digit lit (hex1_num=0) for DWELL_CYCLES
// BLANK1 | both digits dark for BLANK_CYCLES (skipped when 0)
// SHOW2  | right digit lit (hex2_num=0) for DWELL_CYCLES
// BLANK2 | both digits dark for BLANK_CYCLES; reset state
module dual_digit_scan
   import dual_digit_pkg::*;
#(
   parameter int DWELL_CYCLES = 24000,
   parameter int BLANK_CYCLES = 240
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       s1,
   input  logic [3:0]       s2,
   output logic [SEG_W-1:0] seg,
   output logic             hex1_num,
   output logic             hex2_num,
   output logic             frame_tick
);

   localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam int BLANK_TC   = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TC);
   localparam logic             HAS_BLANK  = (BLANK_CYCLES > 0);

   scan_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       d1_q, d2_q, d1_d, d2_d;
   logic             last_cycle;
   logic             enter_show1;
   logic [3:0]       dec_digit;
   logic [SEG_W-1:0] dec_seg;
   logic [SEG_W-1:0] seg_d;
   logic             hex1_d, hex2_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CNT_W'(1);
      last_cycle = 1'b0;

      case (state_q)
         SHOW1, SHOW2: last_cycle = (cnt_q == DWELL_LAST);
         default:      last_cycle = !HAS_BLANK || (cnt_q == BLANK_LAST);
      endcase

      if (last_cycle) begin
         cnt_d = '0;
         case (state_q)
            SHOW1:   state_d = HAS_BLANK ? BLANK1 : SHOW2;
            BLANK1:  state_d = SHOW2;
            SHOW2:   state_d = HAS_BLANK ? BLANK2 : SHOW1;
            default: state_d = SHOW1;
         endcase
      end
   end

   // Inputs are captured only on the transition into SHOW1 so a frame is never torn.
   always_comb begin
      enter_show1 = last_cycle && (state_d == SHOW1);
      d1_d        = enter_show1 ? s1 : d1_q;
      d2_d        = enter_show1 ? s2 : d2_q;
      dec_digit   = (state_d == SHOW1) ? d1_d : d2_d;
   end

   seven_seg_decoder u_decoder (
      .digit (dec_digit),
      .seg   (dec_seg)
   );

   // Outputs are derived from next-state so they switch on the same edge as the FSM.
   always_comb begin
      hex1_d = 1'b1;
      hex2_d = 1'b1;
      seg_d  = SEG_OFF;
      case (state_d)
         SHOW1: begin
            hex1_d = 1'b0;
            seg_d  = dec_seg;
`ifdef DUAL_DIGIT_LZ_BLANK_EN
            if (d1_d == 4'h0) begin
               hex1_d = 1'b1;
               seg_d  = SEG_OFF;
            end
`endif
         end
         SHOW2: begin
            hex2_d = 1'b0;
            seg_d  = dec_seg;
         end
         default: begin
            hex1_d = 1'b1;
            hex2_d = 1'b1;
            seg_d  = SEG_OFF;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= BLANK2;
         cnt_q      <= '0;
         d1_q       <= 4'h0;
         d2_q       <= 4'h0;
         seg        <= SEG_OFF;
         hex1_num   <= 1'b1;
         hex2_num   <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         d1_q       <= d1_d;
         d2_q       <= d2_d;
         seg        <= seg_d;
         hex1_num   <= hex1_d;
         hex2_num   <= hex2_d;
         frame_tick <= enter_show1;
      end
   end

endmodule

// File: tb/tb_dual_digit_scan.sv
// Self-checking bench for dual_digit_scan: cycle tables, directed corner sequences and a frame-phase reference model.
module tb_dual_digit_scan;

   localparam int D  = 4;
   localparam int B1 = 2;
   localparam int B2 = 0;

   typedef struct packed {
      logic [6:0] seg;
      logic       h1;
      logic       h2;
      logic       tick;
   } out_t;

   typedef struct packed {
      logic       rst;
      logic [3:0] a;
      logic [3:0] b;
      logic [6:0] seg;
      logic       h1;
      logic       h2;
      logic       tick;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] s1 = 4'h0, s2 = 4'h0;
   logic [6:0] seg;
   logic       h1, h2, tick;

   logic       rst2 = 1'b1;
   logic [3:0] s1b = 4'hC, s2b = 4'hF;
   logic [6:0] seg_b;
   logic       h1b, h2b, tick_b;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit done     = 0;

   always #5 clk = ~clk;

   dual_digit_scan #(.DWELL_CYCLES(D), .BLANK_CYCLES(B1)) u_dut (
      .clk(clk), .reset(rst), .s1(s1), .s2(s2),
      .seg(seg), .hex1_num(h1), .hex2_num(h2), .frame_tick(tick)
   );

   dual_digit_scan #(.DWELL_CYCLES(D), .BLANK_CYCLES(B2)) u_dut_nb (
      .clk(clk), .reset(rst2), .s1(s1b), .s2(s2b),
      .seg(seg_b), .hex1_num(h1b), .hex2_num(h2b), .frame_tick(tick_b)
   );

   function automatic logic [6:0] hexseg(input logic [3:0] v);
      case (v)
         4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   function automatic logic [6:0] left_seg(input logic [3:0] v);
`ifdef DUAL_DIGIT_LZ_BLANK_EN
      if (v == 4'h0) return 7'h7F;
`endif
      return hexseg(v);
   endfunction

   function automatic logic left_en(input logic [3:0] v);
`ifdef DUAL_DIGIT_LZ_BLANK_EN
      if (v == 4'h0) return 1'b1;
`endif
      return 1'b0;
   endfunction

   // Expected outputs k edges after the last reset edge; the reset edge counts as a blank of at least one cycle.
   function automatic out_t ref_out(input int k, input int b, input logic [3:0] l1, input logic [3:0] l2);
      out_t o;
      int   start, ph;
      o = '{seg: 7'h7F, h1: 1'b1, h2: 1'b1, tick: 1'b0};
      start = (b > 0) ? b : 1;
      if (k < start) return o;
      ph = (k - start) % (2 * (D + b));
      if (ph < D) begin
         o.h1 = left_en(l1); o.seg = left_seg(l1); o.tick = (ph == 0);
      end else if (ph >= D + b && ph < 2 * D + b) begin
         o.h2 = 1'b0; o.seg = hexseg(l2);
      end
      return o;
   endfunction

   function automatic bit is_latch(input int k, input int b);
      int start;
      start = (b > 0) ? b : 1;
      return (k >= start) && (((k - start) % (2 * (D + b))) == 0);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40) $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   // Reference model state for both instances.
   int k1 = 0, k2 = 0;
   bit v1 = 0, v2 = 0;
   logic [3:0] m1a = 0, m1b = 0, m2a = 0, m2b = 0;
   out_t e1, e2;
   int last_tick = -1;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin k1 = 0; m1a = 0; m1b = 0; v1 = 1; end
      else if (v1) begin
         k1++;
         if (is_latch(k1, B1)) begin m1a = s1; m1b = s2; end
      end
      e1 = ref_out(k1, B1, m1a, m1b);
      if (rst2) begin k2 = 0; m2a = 0; m2b = 0; v2 = 1; end
      else if (v2) begin
         k2++;
         if (is_latch(k2, B2)) begin m2a = s1b; m2b = s2b; end
      end
      e2 = ref_out(k2, B2, m2a, m2b);
   end

   always @(negedge clk) begin
      if (v1 && !done) begin
         check("scan_model", {seg, h1, h2, tick}, e1);
         check("enables_exclusive", h1 | h2, 1);
         if (k1 == 0) last_tick = -1;
         if (tick === 1'b1) begin
            if (last_tick >= 0) check("tick_period", cyc - last_tick, 2 * (D + B1));
            last_tick = cyc;
         end
      end
      if (v2 && !done) begin
         check("nb_model", {seg_b, h1b, h2b, tick_b}, e2);
         check("nb_enables_exclusive", h1b | h2b, 1);
         if (k2 >= 1) check("nb_no_dead_cycle", !(h1b && h2b), 1);
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   vec_t tab [17];

   task automatic run_table();
      for (int i = 0; i < 17; i++) begin
         rst = tab[i].rst; s1 = tab[i].a; s2 = tab[i].b;
         step(1);
         check($sformatf("table[%0d]", i), {seg, h1, h2, tick}, {tab[i].seg, tab[i].h1, tab[i].h2, tab[i].tick});
      end
   endtask

   task automatic wait_tick();
      bit ok;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         step(1);
         if (tick === 1'b1) ok = 1;
      end
      check("tick_timeout", ok, 1);
   endtask

   initial begin
      // Test 1 table: 3 reset cycles, 2 dark, SHOW1(4) dark(2) SHOW2(4) dark(2), next frame tick.
      for (int i = 0; i < 17; i++) tab[i] = '{rst: 1'b0, a: 4'h4, b: 4'h5, seg: 7'h7F, h1: 1'b1, h2: 1'b1, tick: 1'b0};
      for (int i = 0; i < 3; i++) tab[i].rst = 1'b1;
      for (int i = 4; i < 8; i++) begin tab[i].h1 = 1'b0; tab[i].seg = 7'b0011001; end
      for (int i = 10; i < 14; i++) begin tab[i].h2 = 1'b0; tab[i].seg = 7'b0010010; end
      tab[4].tick = 1'b1;
      tab[16].h1 = 1'b0; tab[16].seg = 7'b0011001; tab[16].tick = 1'b1;

      run_table();

      // Test 2: change s1 in the 2nd cycle of SHOW2; current frame keeps the old value.
      step(7);
      s1 = 4'h8;
      step(1);
      check("midframe_hold", {seg, h2}, {7'b0010010, 1'b0});
      wait_tick();
      check("new_frame_seg", {seg, h1}, {7'b0000000, 1'b0});

      // Test 5: reset in the 3rd cycle of SHOW1.
      step(2);
      check("in_show1_third", h1, 0);
      rst = 1'b1;
      step(1);
      check("reset_midrun_out", {seg, h1, h2, tick}, {7'h7F, 1'b1, 1'b1, 1'b0});
      check("reset_midrun_d1q", u_dut.d1_q, 0);
      run_table();

      // Test 6: left digit zero.
      s1 = 4'h0; s2 = 4'h5;
      wait_tick();
      check("lz_show1", {seg, h1}, {left_seg(4'h0), left_en(4'h0)});
      step(D + B1);
      check("lz_show2", {seg, h2}, {7'b0010010, 1'b0});

      // Full decode sweep on both digit slots.
      for (int v = 0; v < 16; v++) begin
         s1 = 4'(v); s2 = 4'(15 - v);
         wait_tick();
         if (tick === 1'b1 && s1 == 4'(v)) begin
            wait_tick();
            check($sformatf("decode_left[%0d]", v), {seg, h1}, {left_seg(4'(v)), left_en(4'(v))});
            step(D + B1);
            check($sformatf("decode_right[%0d]", v), {seg, h2}, {hexseg(4'(15 - v)), 1'b0});
         end
      end

      // Test 3: random inputs every cycle with occasional resets.
      for (int i = 0; i < 10000; i++) begin
         s1  = 4'($urandom_range(0, 15));
         s2  = 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 299) == 0);
         step(1);
      end
      rst = 1'b0;
      step(2);

      done = 1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Test 4: zero-blank instance alternates C/F with no dead cycles.
   initial begin
      rst2 = 1'b1;
      step(3);
      rst2 = 1'b0;
      step(1);
      for (int i = 0; i < 16; i++) begin
         if ((i % 8) < D)
            check($sformatf("nb_show1[%0d]", i), {seg_b, h1b, h2b}, {7'b1000110, 1'b0, 1'b1});
         else
            check($sformatf("nb_show2[%0d]", i), {seg_b, h1b, h2b}, {7'b0001110, 1'b1, 1'b0});
         check($sformatf("nb_tick[%0d]", i), tick_b, (i % 8) == 0);
         step(1);
      end
      step(500);
      rst2 = 1'b1;
      step(1);
      check("nb_reset_out", {seg_b, h1b, h2b, tick_b}, {7'h7F, 1'b1, 1'b1, 1'b0});
      rst2 = 1'b0;
      s1b = 4'h3; s2b = 4'hA;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule
